// File: rtl/topk_frame_sort.sv
// topk_frame_sort: keeps the K largest samples of a frame in a sorted list, then dumps the list.
// Define TOPK_MIN_MODE_EN to keep the K smallest samples instead, dumped smallest first.
`default_nettype none

module topk_frame_sort #(
  parameter int W  = 12,
  parameter int K  = 16,
  parameter int CW = $clog2(K)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              DataEn,
  input  logic [W-1:0]      DataIn,
  input  logic              FrameStart,
  input  logic              FrameEnd,
  output logic              DataRdy,
  output logic              OutVld,
  input  logic              OutRdy,
  output logic [W-1:0]      OutData,
  output logic              OutLast,
  output logic              SumVld,
  output logic [W+CW:0]     DataSumOut,
  output logic [CW:0]       CntOut
);

  localparam int SW = W + CW + 1;

  typedef enum logic [0:0] {ACC = 1'b0, DUMP = 1'b1} state_t;

  state_t          state_q;
  logic [W-1:0]    list_q [K];
  logic [W-1:0]    list_d [K];
  logic [W-1:0]    base   [K];
  logic [CW:0]     cnt_q, cnt_d, base_cnt;
  logic [SW-1:0]   sum_q, sum_d, base_sum;
  logic [CW-1:0]   idx_q;
  logic [CW-1:0]   idx_nxt;
  logic            DataRdy_q, OutVld_q, OutLast_q, SumVld_q;
  logic [W-1:0]    OutData_q;
  logic [SW-1:0]   DataSumOut_q;
  logic [CW:0]     CntOut_q;
  logic            full;
  logic [W-1:0]    last;
  int              p;

  // True when an already-stored value stays ahead of a newly arriving one.
  function automatic logic ranks_ahead(input logic [W-1:0] stored, input logic [W-1:0] incoming);
`ifdef TOPK_MIN_MODE_EN
    return stored <= incoming;
`else
    return stored >= incoming;
`endif
  endfunction

  always_comb begin
    base     = list_q;
    base_cnt = cnt_q;
    base_sum = sum_q;
    if (FrameStart) begin
      base_cnt = '0;
      base_sum = '0;
    end
    p = 0;
    for (int i = 0; i < K; i++) begin
      if (i < int'(base_cnt) && ranks_ahead(base[i], DataIn)) p = p + 1;
    end
    full   = (int'(base_cnt) == K);
    last   = base[K-1];
    list_d = base;
    cnt_d  = base_cnt;
    sum_d  = base_sum;
    // A full list only admits a sample that strictly beats its tail entry.
    if (DataEn && (!full || !ranks_ahead(last, DataIn))) begin
      for (int i = 1; i < K; i++) begin
        if (i > p) list_d[i] = base[i-1];
      end
      for (int i = 0; i < K; i++) begin
        if (i == p) list_d[i] = DataIn;
      end
      if (full) begin
        sum_d = base_sum + SW'(DataIn) - SW'(last);
      end else begin
        cnt_d = base_cnt + 1'b1;
        sum_d = base_sum + SW'(DataIn);
      end
    end
  end

  assign idx_nxt = idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ACC;
      for (int i = 0; i < K; i++) list_q[i] <= '0;
      cnt_q        <= '0;
      sum_q        <= '0;
      idx_q        <= '0;
      DataRdy_q    <= 1'b1;
      OutVld_q     <= 1'b0;
      OutLast_q    <= 1'b0;
      OutData_q    <= '0;
      SumVld_q     <= 1'b0;
      DataSumOut_q <= '0;
      CntOut_q     <= '0;
    end else begin
      SumVld_q <= 1'b0;
      case (state_q)
        ACC: begin
          list_q <= list_d;
          cnt_q  <= cnt_d;
          sum_q  <= sum_d;
          if (FrameEnd) begin
            SumVld_q     <= 1'b1;
            DataSumOut_q <= sum_d;
            CntOut_q     <= cnt_d;
            if (cnt_d != '0) begin
              state_q   <= DUMP;
              DataRdy_q <= 1'b0;
              OutVld_q  <= 1'b1;
              OutData_q <= list_d[0];
              OutLast_q <= (cnt_d == (CW+1)'(1));
              idx_q     <= '0;
            end
          end
        end
        DUMP: begin
          if (OutVld_q && OutRdy) begin
            if (OutLast_q) begin
              state_q   <= ACC;
              DataRdy_q <= 1'b1;
              OutVld_q  <= 1'b0;
              OutLast_q <= 1'b0;
              OutData_q <= '0;
              cnt_q     <= '0;
              sum_q     <= '0;
              idx_q     <= '0;
            end else begin
              idx_q     <= idx_nxt;
              OutData_q <= list_q[idx_nxt];
              OutLast_q <= ({1'b0, idx_nxt} == cnt_q - 1'b1);
            end
          end
        end
        default: state_q <= ACC;
      endcase
    end
  end

  assign DataRdy    = DataRdy_q;
  assign OutVld     = OutVld_q;
  assign OutData    = OutData_q;
  assign OutLast    = OutLast_q;
  assign SumVld     = SumVld_q;
  assign DataSumOut = DataSumOut_q;
  assign CntOut     = CntOut_q;

endmodule

`default_nettype wire

// File: tb/tb_topk_frame_sort.sv
// tb_topk_frame_sort: randomized frames against a sort-and-truncate reference for topk_frame_sort.
`default_nettype none

module tb_topk_frame_sort;

  localparam int W  = 8;
  localparam int K  = 4;
  localparam int CW = $clog2(K);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          DataEn = 1'b0;
  logic [W-1:0]  DataIn = '0;
  logic          FrameStart = 1'b0;
  logic          FrameEnd = 1'b0;
  logic          DataRdy;
  logic          OutVld;
  logic          OutRdy = 1'b0;
  logic [W-1:0]  OutData;
  logic          OutLast;
  logic          SumVld;
  logic [W+CW:0] DataSumOut;
  logic [CW:0]   CntOut;

  topk_frame_sort #(.W(W), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .DataEn(DataEn), .DataIn(DataIn), .FrameStart(FrameStart), .FrameEnd(FrameEnd),
    .DataRdy(DataRdy), .OutVld(OutVld), .OutRdy(OutRdy), .OutData(OutData), .OutLast(OutLast),
    .SumVld(SumVld), .DataSumOut(DataSumOut), .CntOut(CntOut)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int exp_q[$];
  int exp_sum;
  int exp_cnt;
  int fr[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: the retained list is the frame's samples ranked and cut to K.
  task automatic model(input int s[$]);
    int t[$];
    t = s;
`ifdef TOPK_MIN_MODE_EN
    t.sort();
`else
    t.rsort();
`endif
    exp_q.delete();
    exp_sum = 0;
    for (int i = 0; i < t.size() && i < K; i++) begin
      exp_q.push_back(t[i]);
      exp_sum += t[i];
    end
    exp_cnt = exp_q.size();
  endtask

  // Starts driving on the current negedge; returns on a negedge with the block back in ACC.
  task automatic run_frame(input int s[$], input int mode);
    int  n, k;
    bit  rdy, done;
    model(s);
    if (s.size() == 0) begin
      DataEn = 1'b0; FrameStart = 1'b1; FrameEnd = 1'b0;
      @(negedge clk);
      FrameStart = 1'b0; FrameEnd = 1'b1;
    end else begin
      for (int i = 0; i < s.size(); i++) begin
        if (i > 0) @(negedge clk);
        chk("data_rdy_acc", DataRdy, 1);
        DataEn     = 1'b1;
        DataIn     = W'(s[i]);
        FrameStart = (i == 0);
        FrameEnd   = (i == s.size() - 1);
      end
    end
    @(negedge clk);
    DataEn = 1'b0; FrameStart = 1'b0; FrameEnd = 1'b0;
    chk("sum_vld", SumVld, 1);
    chk("sum", DataSumOut, exp_sum);
    chk("cnt", CntOut, exp_cnt);
    chk("out_vld_first", OutVld, exp_cnt > 0);
    n = exp_q.size();
    if (n == 0) begin
      @(negedge clk);
      chk("empty_sum_pulse", SumVld, 0);
      chk("empty_out_vld", OutVld, 0);
      chk("empty_data_rdy", DataRdy, 1);
      return;
    end
    k = 0; rdy = 1'b0; done = 1'b0;
    for (int cyc = 0; cyc < 100 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (cyc == 1) chk("sum_pulse", SumVld, 0);
      if (rdy) k++;
      if (k == n) begin
        done = 1'b1;
        DataEn = 1'b0; FrameStart = 1'b0; FrameEnd = 1'b0; OutRdy = 1'b0;
        chk("dump_end_vld", OutVld, 0);
        chk("dump_end_rdy", DataRdy, 1);
      end else begin
        chk("out_vld", OutVld, 1);
        chk("out_data", OutData, exp_q[k]);
        chk("out_last", OutLast, k == n - 1);
        chk("data_rdy_dump", DataRdy, 0);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = 1'($urandom);
          default: rdy = !(cyc >= 1 && cyc <= 3);
        endcase
        OutRdy     = rdy;
        DataEn     = 1'($urandom);
        DataIn     = W'($urandom);
        FrameStart = 1'($urandom);
        FrameEnd   = 1'($urandom);
      end
    end
    if (!done) begin
      chk("dump_timeout", k, n);
      DataEn = 1'b0; FrameStart = 1'b0; FrameEnd = 1'b0; OutRdy = 1'b0;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_data_rdy", DataRdy, 1);
    chk("rst_out_vld", OutVld, 0);
    chk("rst_out_last", OutLast, 0);
    chk("rst_sum_vld", SumVld, 0);
    chk("rst_out_data", OutData, 0);
    chk("rst_sum", DataSumOut, 0);
    chk("rst_cnt", CntOut, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Abort a dump with reset and check the asynchronous clear.
    fr = {4, 2, 8, 6};
    for (int i = 0; i < fr.size(); i++) begin
      if (i > 0) @(negedge clk);
      DataEn = 1'b1; DataIn = W'(fr[i]);
      FrameStart = (i == 0); FrameEnd = (i == fr.size() - 1);
    end
    @(negedge clk);
    DataEn = 1'b0; FrameStart = 1'b0; FrameEnd = 1'b0;
    chk("pre_rst_out_vld", OutVld, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_vld", OutVld, 0);
    chk("async_rst_sum_vld", SumVld, 0);
    chk("async_rst_data_rdy", DataRdy, 1);
    chk("async_rst_cnt", CntOut, 0);
    @(negedge clk);
    rst_n = 1'b1;

    fr = {5, 9, 1, 9, 7, 3};
    run_frame(fr, 0);
    fr = {10, 20};
    run_frame(fr, 1);
    fr.delete();
    for (int i = 0; i < 8; i++) fr.push_back(255);
    run_frame(fr, 1);
    fr.delete();
    run_frame(fr, 0);
    fr = {5, 9, 1, 9, 7, 3};
    run_frame(fr, 2);
    fr = {1, 2};
    run_frame(fr, 0);

    for (int f = 0; f < 40; f++) begin
      int len;
      bit narrow;
      len = $urandom_range(0, 9);
      narrow = 1'($urandom);
      fr.delete();
      for (int i = 0; i < len; i++)
        fr.push_back(narrow ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 255)));
      run_frame(fr, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
